// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: soft-start duty slew controller feeding the PWM duty-load port.
// Accepts a target duty and walks DutyOut toward it in StepSize increments, one
// step every Interval+2 cycles, strobing LoadDuty with each new value.
// Optional feature: define PWM_RAMP_HOLD_EN to add a Hold input that freezes the
// step-interval counter while in WAIT.
module pwm_duty_ramp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             TargetValid,
  input  logic [WIDTH-1:0] TargetIn,
  output logic             TargetReady,
  input  logic [WIDTH-1:0] StepSize,
  input  logic [DIV_W-1:0] Interval,
`ifdef PWM_RAMP_HOLD_EN
  input  logic             Hold,
`endif
  output logic [WIDTH-1:0] DutyOut,
  output logic             LoadDuty,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StStep = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             done_q, done_d;

  logic             hold_w;
  logic             accept;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_floor;
  logic             ramp_up;
  logic [WIDTH-1:0] next_duty;

`ifdef PWM_RAMP_HOLD_EN
  assign hold_w = Hold;
`else
  assign hold_w = 1'b0;
`endif

  // Handshake and status decode straight from the state register.
  assign TargetReady = (state_q != StStep);
  assign Busy        = (state_q != StIdle);
  assign accept      = TargetValid & TargetReady;

  assign DutyOut  = duty_q;
  assign LoadDuty = load_q;
  assign Done     = done_q;

  // Step arithmetic at WIDTH+1 bits so neither direction can wrap.
  always_comb begin
    step_eff = StepSize;
    if (StepSize == '0) begin
      step_eff = {{(WIDTH-1){1'b0}}, 1'b1};
    end
    up_sum   = {1'b0, duty_q} + {1'b0, step_eff};
    // duty - step stays above target only when duty exceeds target + step
    dn_floor = {1'b0, target_q} + {1'b0, step_eff};
    ramp_up  = (duty_q < target_q);
    if (ramp_up) begin
      if (up_sum >= {1'b0, target_q}) begin
        next_duty = target_q;
      end else begin
        next_duty = up_sum[WIDTH-1:0];
      end
    end else begin
      if ({1'b0, duty_q} > dn_floor) begin
        next_duty = duty_q - step_eff;
      end else begin
        next_duty = target_q;
      end
    end
  end

  // Next-state logic for the IDLE / WAIT / STEP sequencer.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    load_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          target_d = TargetIn;
          if (TargetIn == duty_q) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = Interval;
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (accept) begin
          target_d = TargetIn;
        end
        if (accept && (TargetIn == duty_q)) begin
          // Retarget onto the current duty ends the ramp without a strobe.
          state_d = StIdle;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (!hold_w) begin
          if (cnt_q == '0) begin
            state_d = StStep;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      StStep: begin
        duty_d = next_duty;
        load_d = 1'b1;
        if (next_duty == target_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d   = Interval;
          state_d = StWait;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any ramp without a final strobe.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= StIdle;
      duty_q   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      done_q   <= done_d;
    end
  end

endmodule
